manual_entry: RTL

Front-panel input stage for manual instruction entry. Synchronizes and debounces the board mode switch, step button and 15 instruction switches. On each clean button press in manual mode, it latches one switch word and presents it as `man`/`switch` to the downstream instruction encoder for exactly one CPU fetch handshake. It sits between the raw board I/O and the encoder that drives the CPU instruction path.

---
 rtl/manual_entry.sv | 86 ++++++++
 1 files changed

// File: rtl/manual_entry.sv
// manual_entry: synchronizes and debounces front-panel mode/step/switch inputs and
// issues one latched switch word to the instruction encoder per clean button press.
module manual_entry #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_raw,
  input  logic             step_raw,
  input  logic [14:0]      sw_raw,
  input  logic             fetch_ready,
  output logic             man,
  output logic [14:0]      switch,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  logic             mode_s1_q, mode_s2_q, step_s1_q, step_s2_q;
  logic [14:0]      sw_s1_q, sw_s2_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             step_stable_q, step_stable_d, step_stable_dly_q, press;
  state_t           state_q, state_d;
  logic [14:0]      switch_q, switch_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q         <= 1'b0;
      mode_s2_q         <= 1'b0;
      step_s1_q         <= 1'b0;
      step_s2_q         <= 1'b0;
      sw_s1_q           <= '0;
      sw_s2_q           <= '0;
      db_cnt_q          <= '0;
      step_stable_q     <= 1'b0;
      step_stable_dly_q <= 1'b0;
      state_q           <= IDLE;
      switch_q          <= '0;
      issue_count_q     <= '0;
    end else begin
      mode_s1_q         <= mode_raw;
      mode_s2_q         <= mode_s1_q;
      step_s1_q         <= step_raw;
      step_s2_q         <= step_s1_q;
      sw_s1_q           <= sw_raw;
      sw_s2_q           <= sw_s1_q;
      db_cnt_q          <= db_cnt_d;
      step_stable_q     <= step_stable_d;
      step_stable_dly_q <= step_stable_q;
      state_q           <= state_d;
      switch_q          <= switch_d;
      issue_count_q     <= issue_count_d;
    end
  end
  always_comb begin
    db_cnt_d      = '0;
    step_stable_d = step_stable_q;
    if (step_s2_q != step_stable_q) begin
      if (db_cnt_q == DB_MAX) step_stable_d = step_s2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
    press         = step_stable_q & ~step_stable_dly_q;
    state_d       = state_q;
    switch_d      = switch_q;
    issue_count_d = issue_count_q;
    // a completed handshake wins over a simultaneous mode drop
    case (state_q)
      IDLE: if (press && mode_s2_q) begin
        state_d  = ISSUE;
        switch_d = sw_s2_q;
      end
      ISSUE: if (fetch_ready) begin
        state_d       = HOLD;
        issue_count_d = issue_count_q + 1'b1;
      end else if (!mode_s2_q) state_d = IDLE;
      HOLD: if (!step_stable_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign man         = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign switch      = switch_q;
  assign issue_count = issue_count_q;
endmodule
